// File: rtl/uart_receiver_if.sv
// Received-byte stream from uart_receiver (master) to its consumer (slave):
// byte, valid/ready handshake and the per-byte status flags.
interface uart_receiver_if;
    logic [7:0] o_uart_rx_data;
    logic       o_uart_rx_valid;
    logic       i_uart_rx_ready;
    logic       o_parity_err;
    logic       o_frame_err;
    logic       o_overrun;

    modport master (
        output o_uart_rx_data,
        output o_uart_rx_valid,
        output o_parity_err,
        output o_frame_err,
        output o_overrun,
        input  i_uart_rx_ready
    );

    modport slave (
        input  o_uart_rx_data,
        input  o_uart_rx_valid,
        input  o_parity_err,
        input  o_frame_err,
        input  o_overrun,
        output i_uart_rx_ready
    );
endinterface

// File: rtl/uart_receiver.sv
// UART receive path, one line sample per i_u_clk edge, runtime 5-8 data bits,
// none/odd/even parity, 1-3 stop bits. Define UART_RX_ERR_DROP_EN to drop errored frames.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a low sample (start bit) with the line armed
// S_DATA   | shifting in data bits, LSB first, accumulating parity
// S_PARITY | sampling the parity bit and comparing to the expected value
// S_STOP   | sampling stop bits; last one commits the frame
module uart_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic            i_u_clk,
    input  logic            i_u_rst,
    input  logic [3:0]      i_data_bit,
    input  logic [1:0]      i_stop_bit,
    input  logic [1:0]      i_check_bit,
    input  logic            i_uart_rx,
    output logic            o_uart_rx_busy,
    uart_receiver_if.master rx_if
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("uart_receiver: SYNC_STAGES must be 2 or more");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] r_sync;
    logic [1:0]             r_state;
    logic [2:0]             r_cnt;
    logic [3:0]             r_nbits;
    logic [1:0]             r_nstop;
    logic [1:0]             r_check;
    logic [7:0]             r_shift;
    logic                   r_par;
    logic                   r_par_err_p;
    logic                   r_frm_err_p;
    logic                   r_saw_high;
    logic                   r_armed;

    logic [7:0]             r_data;
    logic                   r_valid;
    logic                   r_pe;
    logic                   r_fe;
    logic                   r_ovr;

    logic                   w_s;
    logic [3:0]             w_nbits;
    logic [1:0]             w_nstop;
    logic [7:0]             w_shift_nxt;
    logic [7:0]             w_aligned;
    logic                   w_par_exp;
    logic                   w_last_stop;
    logic                   w_frm_err_fin;
    logic                   w_accept;

    assign w_s           = r_sync[SYNC_STAGES-1];
    assign w_nbits       = (i_data_bit >= 4'd5 && i_data_bit <= 4'd8) ? i_data_bit : 4'd8;
    assign w_nstop       = (i_stop_bit == 2'd0) ? 2'd1 : i_stop_bit;
    assign w_shift_nxt   = {w_s, r_shift[7:1]};
    assign w_aligned     = w_shift_nxt >> (4'd8 - r_nbits);
    assign w_par_exp     = (r_check == 2'd1) ? ~r_par : r_par;
    assign w_last_stop   = (r_state == S_STOP) && (r_cnt == 3'd0);
    assign w_frm_err_fin = r_frm_err_p | ~w_s;
    assign w_accept      = r_valid & rx_if.i_uart_rx_ready;

    always_ff @(posedge i_u_clk or posedge i_u_rst) begin
        if (i_u_rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_uart_rx};
        end
    end

    // r_armed stays low after an all-low (break) frame until the line goes high again.
    always_ff @(posedge i_u_clk or posedge i_u_rst) begin
        if (i_u_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            r_nbits     <= 4'd8;
            r_nstop     <= 2'd1;
            r_check     <= 2'd0;
            r_shift     <= 8'd0;
            r_par       <= 1'b0;
            r_par_err_p <= 1'b0;
            r_frm_err_p <= 1'b0;
            r_saw_high  <= 1'b0;
            r_armed     <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_s) begin
                        r_armed <= 1'b1;
                    end
                    if (!w_s && r_armed) begin
                        r_nbits     <= w_nbits;
                        r_nstop     <= w_nstop;
                        r_check     <= i_check_bit;
                        r_cnt       <= 3'(w_nbits - 4'd1);
                        r_shift     <= 8'd0;
                        r_par       <= 1'b0;
                        r_par_err_p <= 1'b0;
                        r_frm_err_p <= 1'b0;
                        r_saw_high  <= 1'b0;
                        r_state     <= S_DATA;
                    end
                end
                S_DATA: begin
                    r_par      <= r_par ^ w_s;
                    r_saw_high <= r_saw_high | w_s;
                    if (r_cnt == 3'd0) begin
                        r_shift <= w_aligned;
                        r_cnt   <= {1'b0, r_nstop - 2'd1};
                        r_state <= (r_check != 2'd0) ? S_PARITY : S_STOP;
                    end else begin
                        r_shift <= w_shift_nxt;
                        r_cnt   <= r_cnt - 3'd1;
                    end
                end
                S_PARITY: begin
                    r_saw_high <= r_saw_high | w_s;
                    if (w_s != w_par_exp) begin
                        r_par_err_p <= 1'b1;
                    end
                    r_state <= S_STOP;
                end
                default: begin
                    r_saw_high <= r_saw_high | w_s;
                    if (!w_s) begin
                        r_frm_err_p <= 1'b1;
                    end
                    if (r_cnt == 3'd0) begin
                        r_armed <= r_saw_high | w_s;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
            endcase
        end
    end

`ifdef UART_RX_ERR_DROP_EN
    logic w_err;
    assign w_err = r_par_err_p | w_frm_err_fin;

    // Flags become one-cycle pulses; only clean frames reach the held byte.
    always_ff @(posedge i_u_clk or posedge i_u_rst) begin
        if (i_u_rst) begin
            r_data  <= 8'd0;
            r_valid <= 1'b0;
            r_pe    <= 1'b0;
            r_fe    <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ovr <= 1'b0;
            r_pe  <= 1'b0;
            r_fe  <= 1'b0;
            if (w_last_stop && w_err) begin
                r_pe <= r_par_err_p;
                r_fe <= w_frm_err_fin;
                if (w_accept) begin
                    r_valid <= 1'b0;
                end
            end else if (w_last_stop) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                r_ovr   <= r_valid & ~rx_if.i_uart_rx_ready;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end
`else
    // A commit on the accept edge wins and is not an overrun.
    always_ff @(posedge i_u_clk or posedge i_u_rst) begin
        if (i_u_rst) begin
            r_data  <= 8'd0;
            r_valid <= 1'b0;
            r_pe    <= 1'b0;
            r_fe    <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ovr <= 1'b0;
            if (w_last_stop) begin
                r_data  <= r_shift;
                r_pe    <= r_par_err_p;
                r_fe    <= w_frm_err_fin;
                r_valid <= 1'b1;
                r_ovr   <= r_valid & ~rx_if.i_uart_rx_ready;
            end else if (w_accept) begin
                r_valid <= 1'b0;
                r_pe    <= 1'b0;
                r_fe    <= 1'b0;
            end
        end
    end
`endif

    assign rx_if.o_uart_rx_data  = r_data;
    assign rx_if.o_uart_rx_valid = r_valid;
    assign rx_if.o_parity_err    = r_pe;
    assign rx_if.o_frame_err     = r_fe;
    assign rx_if.o_overrun       = r_ovr;
    assign o_uart_rx_busy        = (r_state != S_IDLE);

endmodule
